// File: rtl/word_rotate_align.sv
// rtl/word_rotate_align.sv - sync-word search, verify and lock realigner for left-rotated word streams
// Optional lock-loss statistics counter enabled by WORD_ROTATE_ALIGN_STATS_EN.
module word_rotate_align #(
  parameter int                 WIDTH     = 32,
  parameter int                 DW        = 5,
  parameter logic [WIDTH-1:0]   SYNC      = 32'h1ACFFC1D,
  parameter int                 FRAME_LEN = 16,
  parameter int                 LOCK_CNT  = 3,
  parameter int                 LOSS_CNT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             locked,
  output logic [DW-1:0]    distance
`ifdef WORD_ROTATE_ALIGN_STATS_EN
  ,
  output logic [15:0]      lock_loss_cnt
`endif
);

  localparam int PW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    dist_q, dist_d;
  logic [PW-1:0]    pos_q, pos_d, pos_inc;
  logic [HW-1:0]    hit_q, hit_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d, sof_q, sof_d;
  logic             hit_any, sync_ok;
  logic [DW-1:0]    hit_k;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input logic [DW-1:0] k);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} >> k;
    return dbl[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input logic [DW-1:0] k);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} << k;
    return dbl[2*WIDTH-1:WIDTH];
  endfunction

  // Scan from the top down so the lowest matching rotation wins.
  always_comb begin
    hit_any = 1'b0;
    hit_k   = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (din == rotl(SYNC, DW'(k))) begin
        hit_any = 1'b1;
        hit_k   = DW'(k);
      end
    end
  end

  assign sync_ok = (rotr(din, dist_q) == SYNC);
  assign pos_inc = (pos_q == PW'(FRAME_LEN - 1)) ? '0 : pos_q + PW'(1);

  always_comb begin
    state_d = state_q;
    dist_d  = dist_q;
    pos_d   = pos_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    if (din_valid) begin
      case (state_q)
        SEARCH: begin
          if (hit_any) begin
            dist_d  = hit_k;
            pos_d   = '0;
            hit_d   = HW'(1);
            miss_d  = '0;
            state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          pos_d = pos_inc;
          if (pos_inc == '0) begin
            if (sync_ok) begin
              hit_d = hit_q + HW'(1);
              if (hit_d == HW'(LOCK_CNT)) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end else begin
              // The missing word itself is not searched; search resumes next word.
              state_d = SEARCH;
              pos_d   = '0;
              hit_d   = '0;
              miss_d  = '0;
            end
          end
        end
        LOCKED: begin
          pos_d = pos_inc;
          if (pos_inc == '0) begin
            if (sync_ok) begin
              miss_d = '0;
            end else begin
              miss_d = miss_q + MW'(1);
              if (miss_d == MW'(LOSS_CNT)) begin
                state_d = SEARCH;
                pos_d   = '0;
                hit_d   = '0;
                miss_d  = '0;
              end
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    dout_d = rotr(din, dist_d);
    dv_d   = din_valid && (state_d == LOCKED);
    sof_d  = dv_d && (pos_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      dist_q  <= '0;
      pos_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dist_q  <= dist_d;
      pos_q   <= pos_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      sof_q   <= sof_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign sof        = sof_q;
  assign locked     = (state_q == LOCKED);
  assign distance   = dist_q;

`ifdef WORD_ROTATE_ALIGN_STATS_EN
  logic [15:0] loss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (state_q == LOCKED && state_d == SEARCH && loss_q != 16'hFFFF) begin
      loss_q <= loss_q + 16'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: doc/word_rotate_align.md
# word_rotate_align

- Receive-side realigner for word streams that a transmitter has left-rotated by an unknown constant distance d.
- Searches every rotation of incoming words for a fixed sync word, then confirms the sync recurs at a fixed frame period.
- Once confirmed, locks d and outputs un-rotated (right-rotated by d) words with frame-start markers.
- Sits behind the transmit-side rotator / barrel-shift stage, on the far end of the link.

## Interface

Parameters:
- WIDTH, 32, data word width
- DW, 5, distance width; 2**DW == WIDTH
- SYNC, 32'h1ACFFC1D, sync word; must be aperiodic (no two rotations equal)
- FRAME_LEN, 16, valid words per frame, sync at position 0; must be ≥ 2
- LOCK_CNT, 3, consecutive sync hits (including the first detection) needed to lock; must be ≥ 1
- LOSS_CNT, 2, consecutive sync misses that drop lock; must be ≥ 1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  WIDTH  rotated input word
- din_valid  in  1  din qualifier
- dout  out  WIDTH  realigned word, rotr(din, distance)
- dout_valid  out  1  dout qualifier; only asserted while locked
- sof  out  1  dout is the sync word (frame position 0)
- locked  out  1  alignment locked
- distance  out  DW  captured rotation distance

## Operation

- Convention: transmitter sends rotl(word, d); aligner outputs rotr(din, distance).
- States: SEARCH, VERIFY, LOCKED. Reset state is SEARCH.
- State and counters advance only on cycles with din_valid=1; cycles with din_valid=0 hold all state.
- SEARCH:
  - Compare din against rotl(SYNC, k) for all k in 0..WIDTH-1 in parallel.
  - On a match, capture the lowest matching k into distance, set frame position to 0 and hit count to 1.
  - If LOCK_CNT==1, go directly to LOCKED; otherwise go to VERIFY.
- VERIFY:
  - Frame position increments and wraps at FRAME_LEN-1 → 0.
  - At position 0: if rotr(din, distance)==SYNC, increment hit count; when it reaches LOCK_CNT, go to LOCKED. Otherwise go to SEARCH.
  - VERIFY does not re-search on the word that caused the miss.
  - Non-zero positions are not checked.
- LOCKED:
  - At position 0, a hit clears the miss count; a miss increments it.
  - When the miss count reaches LOSS_CNT, go to SEARCH and clear counters. distance keeps its stale value until the next capture.
- Output, registered: dout = rotr(din, distance_next); dout_valid = din_valid && state_next==LOCKED; sof = dout_valid && position_next==0.
- The word that completes lock is emitted with dout_valid=1 and sof=1. The word that causes loss of lock is suppressed.
- Rotation arithmetic is modulo WIDTH; distance WIDTH-1 is legal.

## Timing

- Latency: din to dout is 1 clk.
- locked, distance, and dout_valid update on the same edge as the state register.
- Reset values, forced asynchronously and immediately on rst_n low: dout=0, dout_valid=0, sof=0, locked=0, distance=0, state=SEARCH, all counters 0.
- Reset asserted mid-frame or while LOCKED: outputs go to 0 without waiting for clk.
- After rst_n is released, the first edge with din_valid=1 is evaluated in SEARCH.
- Minimum time to lock: (LOCK_CNT-1)*FRAME_LEN+1 valid words after the first sync.

## Configuration

- WORD_ROTATE_ALIGN_STATS_EN:
  - Defined: adds output lock_loss_cnt[15:0]. It increments on each LOCKED→SEARCH transition, saturates at 16'hFFFF, and resets to 0.
  - Undefined: port and logic are absent; all other behaviour is identical.

## Test plan

- Lock with d=7, defaults: frames with sync at every 16th valid word. Expect locked to rise 1 clk after the third sync (valid word 32), distance=7, every dout equal to the original word, and sof on each sync.
- Boundary distances d=0 and d=31: expect distance=0 and distance=31 respectively, with dout bit-exact.
- False sync: one rotl(SYNC,5) word, then random data including position 16. Expect return to SEARCH at word 16, locked never asserted, dout_valid=0 throughout.
- Loss of lock with defaults: while locked, corrupt one sync → locked stays 1, no gap in dout_valid. Then corrupt two consecutive syncs → locked falls on the second miss, and that word has dout_valid=0.
- Valid gaps: insert random din_valid=0 cycles, up to 5 in a row. Expect lock at the same valid-word index as the gap-free run and no dout_valid during gaps.
- Reset mid-LOCKED: pull rst_n low between edges. Expect all outputs 0 before the next edge, then relock per the first scenario after release.
